seq_divider: RTL

SEQ_DIVIDER -- requirements
Module: seq_divider

---
 rtl/seq_divider.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/seq_divider.sv
// Sequential sign-magnitude divider: 16-bit dividend magnitude by 7-bit divisor
// magnitude, one restoring-division step per clock, MSB first.
// Optional feature: define DIV_EARLY_TERM_EN to finish in one cycle whenever
// the divisor magnitude is larger than the dividend magnitude (quotient is 0).
module seq_divider (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [16:0] Dividend_in,
   input  logic [7:0]  Divisor_in,
   output logic [16:0] Quot_out,
   output logic [6:0]  Rem_out,
   output logic        busy,
   output logic        done,
   output logic        dz
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;       // completed iterations, 0..16
   logic [15:0] dvd_q, dvd_d;       // dividend bits shift out, quotient bits shift in
   logic [6:0]  dvs_q, dvs_d;       // divisor magnitude
   logic [6:0]  prem_q, prem_d;     // partial remainder
   logic        sign_q, sign_d;     // XOR of operand signs
   logic        zero_q, zero_d;     // divisor magnitude was zero
`ifdef DIV_EARLY_TERM_EN
   logic        early_q, early_d;   // divisor magnitude exceeds dividend magnitude
`endif
   logic [16:0] quot_q, quot_d;
   logic [6:0]  rem_q, rem_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        dz_q, dz_d;

   // Restoring step: shift in next dividend bit, trial-subtract the divisor.
   // When the trial is non-negative the true difference is below 128, so the
   // low 7 bits of a modulo-128 subtraction are exact.
   logic [7:0]  shifted_s;
   logic        ge_s;
   logic [6:0]  diff_s;

   // Datapath for one restoring-division iteration.
   always_comb begin
      shifted_s = {prem_q, dvd_q[15]};
      ge_s      = (shifted_s >= {1'b0, dvs_q});
      diff_s    = shifted_s[6:0] - dvs_q;
   end

   // Next-state, datapath updates and registered-output updates.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      dvd_d   = dvd_q;
      dvs_d   = dvs_q;
      prem_d  = prem_q;
      sign_d  = sign_q;
      zero_d  = zero_q;
`ifdef DIV_EARLY_TERM_EN
      early_d = early_q;
`endif
      quot_d  = quot_q;
      rem_d   = rem_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      dz_d    = dz_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_RUN;
               busy_d  = 1'b1;
               cnt_d   = 5'd0;
               dvd_d   = Dividend_in[15:0];
               dvs_d   = Divisor_in[6:0];
               prem_d  = 7'd0;
               sign_d  = Dividend_in[16] ^ Divisor_in[7];
               zero_d  = (Divisor_in[6:0] == 7'd0);
`ifdef DIV_EARLY_TERM_EN
               early_d = (Divisor_in[6:0] != 7'd0) &&
                         ({9'd0, Divisor_in[6:0]} > Dividend_in[15:0]);
`endif
            end else begin
               state_d = S_IDLE;
            end
         end
         S_RUN: begin
            if (zero_q) begin
               state_d = S_DONE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               dz_d    = 1'b1;
               quot_d  = {sign_q, 16'hFFFF};
               rem_d   = 7'd0;
            end
`ifdef DIV_EARLY_TERM_EN
            else if (early_q) begin
               state_d = S_DONE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               dz_d    = 1'b0;
               quot_d  = 17'd0;
               rem_d   = dvd_q[6:0];
            end
`endif
            else if (cnt_q == 5'd16) begin
               state_d = S_DONE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               dz_d    = 1'b0;
               quot_d  = {sign_q & (dvd_q != 16'd0), dvd_q};
               rem_d   = prem_q;
            end else begin
               cnt_d  = cnt_q + 5'd1;
               dvd_d  = {dvd_q[14:0], ge_s};
               prem_d = ge_s ? diff_s : shifted_s[6:0];
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State and output registers, cleared asynchronously by reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         cnt_q   <= 5'd0;
         dvd_q   <= 16'd0;
         dvs_q   <= 7'd0;
         prem_q  <= 7'd0;
         sign_q  <= 1'b0;
         zero_q  <= 1'b0;
`ifdef DIV_EARLY_TERM_EN
         early_q <= 1'b0;
`endif
         quot_q  <= 17'd0;
         rem_q   <= 7'd0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         dz_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         dvd_q   <= dvd_d;
         dvs_q   <= dvs_d;
         prem_q  <= prem_d;
         sign_q  <= sign_d;
         zero_q  <= zero_d;
`ifdef DIV_EARLY_TERM_EN
         early_q <= early_d;
`endif
         quot_q  <= quot_d;
         rem_q   <= rem_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         dz_q    <= dz_d;
      end
   end

   assign Quot_out = quot_q;
   assign Rem_out  = rem_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign dz       = dz_q;

endmodule
